// File: rtl/frame_scaler_if.sv
// Control, pixel-ROM and frame-RAM signals of the frame scaler; the master side
// is the run controller plus ROM, the slave side is the scaling engine.
interface frame_scaler_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
) ();
    logic              start;
    logic [1:0]        mode;
    logic [2:0]        factor;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_data;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [PIX_W-1:0]  ram_data;
    logic              ram_wren;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, mode, factor, rom_data,
        input  rom_addr, ram_wraddr, ram_data, ram_wren, busy, done, err
    );

    modport slave (
        input  start, mode, factor, rom_data,
        output rom_addr, ram_wraddr, ram_data, ram_wren, busy, done, err
    );
endinterface

// File: rtl/frame_scaler.sv
// Copy / replicate / point-decimate / block-average scaler from pixel ROM into frame RAM.
// First write ROM_LAT+1 cycles after start (after F^2 reads when averaging); no backpressure.
module frame_scaler #(
    parameter int SRC_W      = 160,
    parameter int SRC_H      = 120,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 19,
    parameter int MAX_FACTOR = 4,
    parameter int ROM_LAT    = 1
) (
    input logic           clk,
    input logic           reset,
    frame_scaler_if.slave bus
);
    localparam int CW    = $clog2(SRC_W + 2 * MAX_FACTOR + 1);
    localparam int RW    = $clog2(SRC_H + 2 * MAX_FACTOR + 1);
    localparam int ACC_W = PIX_W + 4;
    localparam int DCW   = $clog2(ROM_LAT + 2);

    localparam logic [1:0] M_COPY = 2'b00, M_REP = 2'b01, M_AVG = 2'b11;
    localparam logic [CW-1:0]     W_C     = CW'(SRC_W);
    localparam logic [CW-1:0]     W_LAST  = CW'(SRC_W - 1);
    localparam logic [RW-1:0]     H_R     = RW'(SRC_H);
    localparam logic [RW-1:0]     H_LAST  = RW'(SRC_H - 1);
    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(SRC_W);
    localparam logic [2:0]        MF      = 3'(MAX_FACTOR);
    localparam logic [DCW-1:0]    DC_LAST = DCW'(ROM_LAT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q;
    logic [2:0]        f_q, fm1_q, f_in;
    logic [ADDR_W-1:0] rstep_q;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     sr_q, sr_d;
    logic [ADDR_W-1:0] rowb_q, rowb_d, boff_q, boff_d, dst_q, rom_addr_q, rom_addr_d;
    logic [2:0]        ux_q, ux_d, uy_q, uy_d;
    logic [DCW-1:0]    dcnt_q;
    logic              done_q, err_q, legal, accept;
    logic              is_last, blk_first, blk_last, ux_wrap, uy_wrap, col_end, row_end, adv;

    logic              pv_q [ROM_LAT];
    logic              pf_q [ROM_LAT];
    logic              pl_q [ROM_LAT];
    logic [ADDR_W-1:0] pd_q [ROM_LAT];

    logic [ACC_W-1:0]  acc_q, acc_sum;
    logic [2:0]        shf;
    logic              ram_wren_q;
    logic [ADDR_W-1:0] ram_wraddr_q;
    logic [PIX_W-1:0]  ram_data_q;

    // F*SRC_W built from shifted copies so no multiplier appears in the address path
    function automatic logic [ADDR_W-1:0] row_step(input logic [2:0] f);
        return (f[0] ? W_A : '0) + (f[1] ? (W_A << 1) : '0) + (f[2] ? (W_A << 2) : '0);
    endfunction

    always_comb begin
        legal = 1'b0;
        case (bus.mode)
            2'b00:        legal = 1'b1;
            2'b01, 2'b10: legal = (bus.factor != 3'd0) && (bus.factor <= MF);
            default:      legal = ((bus.factor == 3'd1) || (bus.factor == 3'd2) ||
                                   (bus.factor == 3'd4)) && (bus.factor <= MF);
        endcase
        f_in   = (bus.mode == M_COPY) ? 3'd1 : bus.factor;
        accept = bus.start && (state_q == S_IDLE) && legal;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (is_last) state_d = S_DRAIN;
            S_DRAIN: if (dcnt_q == DC_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE);

    // Counters always describe the read currently on rom_addr; _d is the following read.
    always_comb begin
        col_d   = col_q;
        sr_d    = sr_q;
        rowb_d  = rowb_q;
        boff_d  = boff_q;
        ux_d    = ux_q;
        uy_d    = uy_q;
        is_last = 1'b0;
        adv     = 1'b1;
        ux_wrap = (ux_q == fm1_q);
        uy_wrap = (uy_q == fm1_q);
        blk_first = (mode_q == M_AVG) ? (ux_q == 3'd0 && uy_q == 3'd0) : 1'b1;
        blk_last  = (mode_q == M_AVG) ? (ux_wrap && uy_wrap) : 1'b1;
        col_end = ((col_q + CW'({f_q, 1'b0})) > W_C);
        row_end = ((sr_q + RW'({f_q, 1'b0})) > H_R);
        if (mode_q == M_REP) begin
            ux_d = ux_wrap ? 3'd0 : ux_q + 3'd1;
            if (ux_wrap) begin
                if (col_q != W_LAST) begin
                    col_d = col_q + CW'(1);
                end else begin
                    col_d = '0;
                    uy_d  = uy_wrap ? 3'd0 : uy_q + 3'd1;
                    if (uy_wrap) begin
                        if (sr_q == H_LAST) begin
                            is_last = 1'b1;
                        end else begin
                            sr_d   = sr_q + RW'(1);
                            rowb_d = rowb_q + W_A;
                        end
                    end
                end
            end
        end else begin
            if (mode_q == M_AVG) begin
                ux_d = ux_wrap ? 3'd0 : ux_q + 3'd1;
                if (ux_wrap) begin
                    uy_d   = uy_wrap ? 3'd0 : uy_q + 3'd1;
                    boff_d = uy_wrap ? '0 : boff_q + W_A;
                end
                adv = ux_wrap && uy_wrap;
            end
            if (adv) begin
                if (col_end) begin
                    col_d = '0;
                    if (row_end) begin
                        is_last = 1'b1;
                    end else begin
                        sr_d   = sr_q + RW'(f_q);
                        rowb_d = rowb_q + rstep_q;
                    end
                end else begin
                    col_d = col_q + CW'(f_q);
                end
            end
        end
        if (state_q != S_RUN) is_last = 1'b0;
        rom_addr_d = rowb_d + boff_d + ADDR_W'(col_d) + ((mode_q == M_AVG) ? ADDR_W'(ux_d) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= M_REP;
            f_q        <= 3'd1;
            fm1_q      <= 3'd0;
            rstep_q    <= '0;
            col_q      <= '0;
            sr_q       <= '0;
            rowb_q     <= '0;
            boff_q     <= '0;
            ux_q       <= '0;
            uy_q       <= '0;
            dst_q      <= '0;
            rom_addr_q <= '0;
            dcnt_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= (state_q == S_DRAIN) && (dcnt_q == DC_LAST);
            dcnt_q <= (state_q == S_DRAIN) ? dcnt_q + DCW'(1) : '0;
            if (bus.start && state_q == S_IDLE) err_q <= ~legal;
            if (accept) begin
                mode_q     <= (bus.mode == M_COPY) ? M_REP : bus.mode;
                f_q        <= f_in;
                fm1_q      <= f_in - 3'd1;
                rstep_q    <= row_step(f_in);
                col_q      <= '0;
                sr_q       <= '0;
                rowb_q     <= '0;
                boff_q     <= '0;
                ux_q       <= '0;
                uy_q       <= '0;
                dst_q      <= '0;
                rom_addr_q <= '0;
            end else if (state_q == S_RUN && !is_last) begin
                col_q      <= col_d;
                sr_q       <= sr_d;
                rowb_q     <= rowb_d;
                boff_q     <= boff_d;
                ux_q       <= ux_d;
                uy_q       <= uy_d;
                dst_q      <= dst_q + (blk_last ? ADDR_W'(1) : '0);
                rom_addr_q <= rom_addr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) pv_q[i] <= 1'b0;
        end else begin
            pv_q[0] <= (state_q == S_RUN);
            for (int i = 1; i < ROM_LAT; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pf_q[0] <= blk_first;
        pl_q[0] <= blk_last;
        pd_q[0] <= dst_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            pf_q[i] <= pf_q[i-1];
            pl_q[i] <= pl_q[i-1];
            pd_q[i] <= pd_q[i-1];
        end
    end

    always_comb begin
        acc_sum = (pf_q[ROM_LAT-1] ? '0 : acc_q) + ACC_W'(bus.rom_data);
        case (f_q)
            3'd2:    shf = 3'd2;
            3'd4:    shf = 3'd4;
            default: shf = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            ram_wren_q   <= 1'b0;
            ram_wraddr_q <= '0;
            ram_data_q   <= '0;
        end else begin
            ram_wren_q <= pv_q[ROM_LAT-1] && pl_q[ROM_LAT-1];
            if (pv_q[ROM_LAT-1]) acc_q <= acc_sum;
            if (pv_q[ROM_LAT-1] && pl_q[ROM_LAT-1]) begin
                ram_wraddr_q <= pd_q[ROM_LAT-1];
                ram_data_q   <= (mode_q == M_AVG) ? PIX_W'(acc_sum >> shf) : bus.rom_data;
            end
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.ram_wren   = ram_wren_q;
    assign bus.ram_wraddr = ram_wraddr_q;
    assign bus.ram_data   = ram_data_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_frame_scaler.sv
// Bench for frame_scaler: vector table, hand-written corner sequences and random runs
// compared against a raster-order reference model of the scaled image.
module tb_frame_scaler;
    localparam int SRC_W = 4, SRC_H = 2, PIX_W = 8, ADDR_W = 19, MAX_FACTOR = 4, ROM_LAT = 1;
    localparam int NPIX = SRC_W * SRC_H;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_scaler_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

    frame_scaler #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
        .MAX_FACTOR(MAX_FACTOR), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    logic [7:0] rom_mem [NPIX];
    always @(posedge clk)
        bus.rom_data <= (bus.rom_addr < ADDR_W'(NPIX)) ? rom_mem[bus.rom_addr[2:0]] : 8'hEE;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int exp_q[$];
    int cap_a[$], cap_d[$], cap_c[$];

    typedef struct {
        logic [1:0] m;
        logic [2:0] f;
        bit         ok;
        int         cnt;
        bit         poke;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int src(input int x, input int y);
        return int'(rom_mem[y * SRC_W + x]);
    endfunction

    function automatic bit legal_ref(input int m, input int f);
        if (m == 0) return 1'b1;
        if (m == 1 || m == 2) return (f >= 1 && f <= MAX_FACTOR);
        return ((f == 1 || f == 2 || f == 4) && f <= MAX_FACTOR);
    endfunction

    task automatic build_exp(input int m, input int f);
        int ff, ow, oh, sum;
        exp_q.delete();
        ff = (m == 0) ? 1 : f;
        if (m <= 1) begin ow = SRC_W * ff; oh = SRC_H * ff; end
        else        begin ow = SRC_W / ff; oh = SRC_H / ff; end
        for (int dy = 0; dy < oh; dy++)
            for (int dx = 0; dx < ow; dx++) begin
                if (m <= 1)      exp_q.push_back(src(dx / ff, dy / ff));
                else if (m == 2) exp_q.push_back(src(dx * ff, dy * ff));
                else begin
                    sum = 0;
                    for (int by = 0; by < ff; by++)
                        for (int bx = 0; bx < ff; bx++) sum += src(dx * ff + bx, dy * ff + by);
                    exp_q.push_back(sum / (ff * ff));
                end
            end
    endtask

    task automatic wait_done(output bit ok, output int nwr);
        ok = 1'b0;
        nwr = 0;
        for (int n = 0; n < 500 && !ok; n++) begin
            if (bus.ram_wren) nwr++;
            if (bus.done) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic run(input logic [1:0] m, input logic [2:0] f, input int exp_cnt,
                       input bit exp_ok, input bit poke);
        int e0, done_c, activity, step, ff;
        bit got_done, busy_at_done;
        cap_a.delete(); cap_d.delete(); cap_c.delete();
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.factor = f;
        @(negedge clk);
        e0 = cyc;
        bus.start = 1'b0;
        bus.mode = 2'($urandom); bus.factor = 3'($urandom);
        chk("err_after_start", bus.err, !exp_ok);
        chk("busy_after_start", bus.busy, exp_ok);
        if (!exp_ok) begin
            activity = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.ram_wren || bus.done || bus.busy) activity++;
            end
            chk("reject_quiet", activity, 0);
            chk("reject_err_sticky", bus.err, 1);
            return;
        end
        chk("rom_addr_first", bus.rom_addr, 0);
        got_done = 1'b0; busy_at_done = 1'b1; done_c = 0;
        for (int n = 0; n < 2000 && !got_done; n++) begin
            if (poke) begin
                bus.start = (n == 3); bus.mode = 2'b11; bus.factor = 3'd3;
            end
            if (bus.ram_wren) begin
                cap_a.push_back(int'(bus.ram_wraddr));
                cap_d.push_back(int'(bus.ram_data));
                cap_c.push_back(cyc);
            end
            if (bus.done) begin
                got_done = 1'b1; done_c = cyc; busy_at_done = bus.busy;
            end else begin
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        chk("done_seen", got_done, 1);
        chk("write_count", cap_a.size(), exp_cnt);
        for (int i = 0; i < cap_a.size(); i++) begin
            chk("wr_addr", cap_a[i], i);
            if (i < exp_q.size()) chk("wr_data", cap_d[i], exp_q[i]);
        end
        ff = (m == 2'b00) ? 1 : int'(f);
        step = (m == 2'b11) ? ff * ff : 1;
        if (cap_c.size() > 0) begin
            chk("first_write_cycle", cap_c[0], e0 + ROM_LAT + 1 + step - 1);
            for (int i = 1; i < cap_c.size(); i++) chk("write_spacing", cap_c[i] - cap_c[i-1], step);
            chk("done_after_last", done_c, cap_c[cap_c.size()-1] + 1);
        end
        chk("busy_low_at_done", busy_at_done, 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("err_clear_after_run", bus.err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int nwr;
        logic [1:0] rm;
        logic [2:0] rf;
        int rowv[8];

        tbl[0]  = '{2'b00, 3'd0, 1'b1,   8, 1'b0};
        tbl[1]  = '{2'b00, 3'd7, 1'b1,   8, 1'b0};
        tbl[2]  = '{2'b01, 3'd2, 1'b1,  32, 1'b1};
        tbl[3]  = '{2'b10, 3'd2, 1'b1,   2, 1'b0};
        tbl[4]  = '{2'b11, 3'd2, 1'b1,   2, 1'b0};
        tbl[5]  = '{2'b11, 3'd3, 1'b0,   0, 1'b0};
        tbl[6]  = '{2'b11, 3'd1, 1'b1,   8, 1'b0};
        tbl[7]  = '{2'b01, 3'd0, 1'b0,   0, 1'b0};
        tbl[8]  = '{2'b01, 3'd5, 1'b0,   0, 1'b0};
        tbl[9]  = '{2'b01, 3'd3, 1'b1,  72, 1'b1};
        tbl[10] = '{2'b10, 3'd0, 1'b0,   0, 1'b0};
        tbl[11] = '{2'b01, 3'd4, 1'b1, 128, 1'b0};
        tbl[12] = '{2'b10, 3'd1, 1'b1,   8, 1'b1};
        tbl[13] = '{2'b11, 3'd5, 1'b0,   0, 1'b0};

        reset = 1'b1; bus.start = 1'b0; bus.mode = 2'b00; bus.factor = 3'd0;
        for (int i = 0; i < NPIX; i++) rom_mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.rom_addr, bus.ram_wraddr, bus.ram_data, bus.ram_wren,
                              bus.busy, bus.done, bus.err}, 0);
        reset = 1'b0;

        for (int v = 0; v < 14; v++) begin
            if (tbl[v].ok) build_exp(int'(tbl[v].m), int'(tbl[v].f));
            else exp_q.delete();
            run(tbl[v].m, tbl[v].f, tbl[v].cnt, tbl[v].ok, tbl[v].poke);
            if (tbl[v].m == 2'b11 && tbl[v].f == 3'd2 && cap_d.size() == 2) begin
                chk("avg_block0", cap_d[0], 2);
                chk("avg_block1", cap_d[1], 4);
            end
            if (tbl[v].m == 2'b01 && tbl[v].f == 3'd2 && cap_d.size() == 32) begin
                rowv = '{0, 0, 1, 1, 2, 2, 3, 3};
                for (int i = 0; i < 8; i++) chk("rep_row0", cap_d[i], rowv[i]);
                rowv = '{4, 4, 5, 5, 6, 6, 7, 7};
                for (int i = 0; i < 8; i++) chk("rep_row3", cap_d[24 + i], rowv[i]);
            end
        end

        // back-to-back run: start issued in the done cycle must be accepted
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b00; bus.factor = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(ok, nwr);
        chk("chain_first_done", ok, 1);
        chk("chain_first_writes", nwr, 8);
        bus.start = 1'b1; bus.mode = 2'b10; bus.factor = 3'd2;
        @(negedge clk);
        bus.start = 1'b0;
        chk("chain_start_in_done", bus.busy, 1);
        wait_done(ok, nwr);
        chk("chain_second_done", ok, 1);
        chk("chain_second_writes", nwr, 2);
        @(negedge clk);

        // reset in the middle of a replicate run
        bus.start = 1'b1; bus.mode = 2'b01; bus.factor = 3'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrun_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_reset_outputs", {bus.rom_addr, bus.ram_wraddr, bus.ram_data, bus.ram_wren,
                                     bus.busy, bus.done, bus.err}, 0);
        nwr = 0;
        repeat (2) begin @(negedge clk); if (bus.ram_wren || bus.done) nwr++; end
        reset = 1'b0;
        repeat (10) begin @(negedge clk); if (bus.ram_wren || bus.done || bus.busy) nwr++; end
        chk("midrun_no_activity", nwr, 0);

        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NPIX; i++) rom_mem[i] = 8'($urandom_range(0, 255));
            rm = 2'($urandom_range(0, 3));
            rf = 3'($urandom_range(0, 7));
            if ((rm == 2'b10 && (rf == 3'd3 || rf == 3'd4)) || (rm == 2'b11 && rf == 3'd4)) rf = 3'd2;
            ok = legal_ref(int'(rm), int'(rf));
            if (ok) build_exp(int'(rm), int'(rf));
            else exp_q.delete();
            run(rm, rf, exp_q.size(), ok, (exp_q.size() >= 4) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
